core_memory_responder: RTL

//  Memory-side responder for the core memory bus driven by the core arbiter (i_MEM_*/o_MEM_* pair).

---
 rtl/core_memory_responder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/core_memory_responder.sv
// Burst memory responder for the core memory bus: wrapped BURST_LEN-beat reads/writes of an internal SRAM.
// Optional CORE_MEMORY_RESPONDER_WAIT_STATE_EN inserts one idle cycle between consecutive beats.
module core_memory_responder #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 21,
  parameter int BURST_LEN      = 4,
  parameter int LATENCY        = 2,
  parameter int MEM_DEPTH_LOG2 = 10
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset,
  input  logic                     i_MEM_Valid,
  input  logic [ADDRESS_WIDTH-1:0] i_MEM_Address,
  input  logic                     i_MEM_Read_Write_n,
  input  logic [DATA_WIDTH-1:0]    i_MEM_Data,
  output logic                     o_MEM_Data_Read,
  output logic [DATA_WIDTH-1:0]    o_MEM_Data,
  output logic                     o_MEM_Valid,
  output logic                     o_MEM_Last
);

  localparam int BW = $clog2(BURST_LEN);
  localparam int LW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

`ifdef CORE_MEMORY_RESPONDER_WAIT_STATE_EN
  localparam bit WAIT_STATES = 1'b1;
`else
  localparam bit WAIT_STATES = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READ_BURST,
    ST_WRITE_BURST
  } state_t;

  state_t                    state_q, state_d;
  logic [LW-1:0]             lat_q, lat_d;
  logic [BW-1:0]             beat_q, beat_d;
  logic                      gap_q, gap_d;
  logic [MEM_DEPTH_LOG2-1:0] base_q, base_d;
  logic                      rw_q, rw_d;
  logic                      drive;
  logic                      valid_d, dread_d, last_d;
  logic [MEM_DEPTH_LOG2-1:0] rd_idx, wr_idx;

  logic [DATA_WIDTH-1:0] mem [0:(1<<MEM_DEPTH_LOG2)-1];

  // Upper address bits select nothing: the array aliases across them.
  logic unused_addr_bits;
  assign unused_addr_bits = ^i_MEM_Address[ADDRESS_WIDTH-1:MEM_DEPTH_LOG2];

  // Critical-word-first wrap: only the in-block offset advances, modulo BURST_LEN.
  function automatic logic [MEM_DEPTH_LOG2-1:0] beat_index(
    input logic [MEM_DEPTH_LOG2-1:0] base,
    input logic [BW-1:0]             beat
  );
    logic [MEM_DEPTH_LOG2-1:0] a;
    a         = base;
    a[BW-1:0] = base[BW-1:0] + beat;
    return a;
  endfunction

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    gap_d   = 1'b0;
    base_d  = base_q;
    rw_d    = rw_q;
    drive   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_MEM_Valid) begin
          base_d = i_MEM_Address[MEM_DEPTH_LOG2-1:0];
          rw_d   = i_MEM_Read_Write_n;
          beat_d = '0;
          lat_d  = '0;
          if (LATENCY == 1) begin
            drive   = 1'b1;
            state_d = i_MEM_Read_Write_n ? ST_READ_BURST : ST_WRITE_BURST;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (lat_q == LW'(LATENCY - 2)) begin
          drive   = 1'b1;
          state_d = rw_q ? ST_READ_BURST : ST_WRITE_BURST;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      default: begin
        // gap_q marks the inserted idle cycle; a beat cycle always has gap_q == 0.
        if (beat_q == LAST_BEAT && !gap_q) begin
          state_d = ST_IDLE;
        end else if (WAIT_STATES && !gap_q) begin
          gap_d = 1'b1;
        end else begin
          beat_d = beat_q + 1'b1;
          drive  = 1'b1;
        end
      end
    endcase

    valid_d = drive & rw_d;
    dread_d = drive & ~rw_d;
    last_d  = drive & (beat_d == LAST_BEAT);
    rd_idx  = beat_index(base_d, beat_d);
  end

  assign wr_idx = beat_index(base_q, beat_q);

  // Outputs are registered together with the state that owns them.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q         <= ST_IDLE;
      lat_q           <= '0;
      beat_q          <= '0;
      gap_q           <= 1'b0;
      base_q          <= '0;
      rw_q            <= 1'b1;
      o_MEM_Valid     <= 1'b0;
      o_MEM_Data_Read <= 1'b0;
      o_MEM_Last      <= 1'b0;
      o_MEM_Data      <= '0;
    end else begin
      state_q         <= state_d;
      lat_q           <= lat_d;
      beat_q          <= beat_d;
      gap_q           <= gap_d;
      base_q          <= base_d;
      rw_q            <= rw_d;
      o_MEM_Valid     <= valid_d;
      o_MEM_Data_Read <= dread_d;
      o_MEM_Last      <= last_d;
      o_MEM_Data      <= valid_d ? mem[rd_idx] : '0;
    end
  end

  // A write beat is the cycle Data_Read is high; the word lands on the edge closing it.
  always_ff @(posedge i_Clk) begin
    if (o_MEM_Data_Read) begin
      mem[wr_idx] <= i_MEM_Data;
    end
  end

endmodule
